// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU instruction sequencer: state encodings,
// opcode constants and the opcode-to-execute-class decode.
package alu_seq_pkg;

  localparam int NREG_DEF = 16;
  localparam int OPC_W    = 5;
  localparam int RIDX_W   = 4;

  // State encodings kept as plain constants so existing tooling that
  // probes the state register keeps seeing the same values.
  localparam logic [3:0] S_IDLE = 4'd0;
  localparam logic [3:0] S_T0   = 4'd1;
  localparam logic [3:0] S_T1   = 4'd2;
  localparam logic [3:0] S_T1W  = 4'd3;
  localparam logic [3:0] S_T2   = 4'd4;
  localparam logic [3:0] S_T3   = 4'd5;
  localparam logic [3:0] S_T4   = 4'd6;
  localparam logic [3:0] S_T5   = 4'd7;
  localparam logic [3:0] S_T6   = 4'd8;

  // Opcodes handled by the register-register sequencer.
  localparam logic [OPC_W-1:0] OP_ADD  = 5'b00011;
  localparam logic [OPC_W-1:0] OP_SUB  = 5'b00100;
  localparam logic [OPC_W-1:0] OP_AND  = 5'b00101;
  localparam logic [OPC_W-1:0] OP_OR   = 5'b00110;
  localparam logic [OPC_W-1:0] OP_ROR  = 5'b00111;
  localparam logic [OPC_W-1:0] OP_ROL  = 5'b01000;
  localparam logic [OPC_W-1:0] OP_SHR  = 5'b01001;
  localparam logic [OPC_W-1:0] OP_SHRA = 5'b01010;
  localparam logic [OPC_W-1:0] OP_SHL  = 5'b01011;
  localparam logic [OPC_W-1:0] OP_MUL  = 5'b01111;
  localparam logic [OPC_W-1:0] OP_DIV  = 5'b10000;
  localparam logic [OPC_W-1:0] OP_NEG  = 5'b10001;
  localparam logic [OPC_W-1:0] OP_NOT  = 5'b10010;

  // Execute-phase shape of an instruction.
  typedef enum logic [1:0] {
    CLS_ILLEGAL = 2'd0,  // no strobes, illegal pulse in T3
    CLS_BIN     = 2'd1,  // Rb->Y, Rc op Y -> Z, Z low -> Ra
    CLS_MULDIV  = 2'd2,  // Ra->Y, Rb op Y -> Z, Z low -> LO, Z high -> HI
    CLS_UNARY   = 2'd3   // op Rb -> Z, Z low -> Ra
  } op_class_e;

  function automatic op_class_e decode_class(input logic [OPC_W-1:0] op);
    op_class_e cls;
    cls = CLS_ILLEGAL;
    if (op >= OP_ADD && op <= OP_SHL) begin
      cls = CLS_BIN;
    end else if (op == OP_MUL || op == OP_DIV) begin
      cls = CLS_MULDIV;
    end else if (op == OP_NEG || op == OP_NOT) begin
      cls = CLS_UNARY;
    end
    return cls;
  endfunction

endpackage

// File: rtl/reg_onehot_dec.sv
// Register index to one-hot enable vector; all zeros when disabled or when
// the index falls outside the register file.
module reg_onehot_dec
  import alu_seq_pkg::*;
#(
  parameter int NREG = NREG_DEF
) (
  input  logic              en_i,
  input  logic [RIDX_W-1:0] idx_i,
  output logic [NREG-1:0]   onehot_o
);

  // One bit per register, set only for the selected index.
  always_comb begin
    onehot_o = '0;
    for (int unsigned i = 0; i < NREG; i++) begin
      onehot_o[i] = en_i && (idx_i == RIDX_W'(i));
    end
  end

endmodule

// File: rtl/alu_sequencer.sv
// Hardwired control sequencer for register-register ALU instructions:
// fetch (T0..T2, with T1W memory wait) then execute (T3..T6). Outputs are
// Moore-decoded from the state and the IR fields latched when leaving T2.
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int NREG = NREG_DEF,
  parameter int OPW  = OPC_W
) (
  input  logic            clock,
  input  logic            clear,
  input  logic            run,
  input  logic [31:0]     ir,
  input  logic            mem_ready,
  output logic [NREG-1:0] Rin,
  output logic [NREG-1:0] Rout,
  output logic            PCout,
  output logic            incPC,
  output logic            MARin,
  output logic            PCin,
  output logic            read,
  output logic            MDRin,
  output logic            MDRout,
  output logic            IRin,
  output logic            Yin,
  output logic            Zin,
  output logic            ZLowOut,
  output logic            ZHighOut,
  output logic            LOin,
  output logic            HIin,
  output logic [OPW-1:0]  opcode,
  output logic            busy,
  output logic            illegal
);

  logic [3:0]        state_q, state_d;
  logic [3:0]        done_st;
  logic [OPW-1:0]    op_q;
  logic [RIDX_W-1:0] ra_q, rb_q, rc_q;
  op_class_e         cls;

  logic              rin_en;
  logic              rout_en;
  logic [RIDX_W-1:0] rout_idx;

  // Low IR bits carry no register-register information.
  logic unused_ir;
  assign unused_ir = ^ir[14:0];

  assign cls = decode_class(OPC_W'(op_q));

  // Where an instruction ends: straight into the next fetch or back to idle.
  assign done_st = run ? S_T0 : S_IDLE;

  // State register; clear forces IDLE immediately so every strobe drops at once.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Capture opcode and register fields as the IR is loaded (edge leaving T2).
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      op_q <= '0;
      ra_q <= '0;
      rb_q <= '0;
      rc_q <= '0;
    end else if (state_q == S_T2) begin
      op_q <= ir[31 -: OPW];
      ra_q <= ir[26:23];
      rb_q <= ir[22:19];
      rc_q <= ir[18:15];
    end
  end

  // Next-state sequencing; execute length depends on the opcode class.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (run) state_d = S_T0;
      S_T0:   state_d = S_T1;
      S_T1:   state_d = mem_ready ? S_T2 : S_T1W;
      S_T1W:  if (mem_ready) state_d = S_T2;
      S_T2:   state_d = S_T3;
      S_T3:   state_d = (cls == CLS_ILLEGAL) ? done_st : S_T4;
      S_T4:   state_d = (cls == CLS_UNARY) ? done_st : S_T5;
      S_T5:   state_d = (cls == CLS_MULDIV) ? S_T6 : done_st;
      S_T6:   state_d = done_st;
      default: state_d = S_IDLE;
    endcase
  end

  // Strobe decode; at most one bus driver is enabled in any state.
  always_comb begin
    PCout    = 1'b0;
    incPC    = 1'b0;
    MARin    = 1'b0;
    PCin     = 1'b0;
    read     = 1'b0;
    MDRin    = 1'b0;
    MDRout   = 1'b0;
    IRin     = 1'b0;
    Yin      = 1'b0;
    Zin      = 1'b0;
    ZLowOut  = 1'b0;
    ZHighOut = 1'b0;
    LOin     = 1'b0;
    HIin     = 1'b0;
    illegal  = 1'b0;
    opcode   = '0;
    rin_en   = 1'b0;
    rout_en  = 1'b0;
    rout_idx = rb_q;
    busy     = (state_q != S_IDLE);
    case (state_q)
      S_T0: begin
        PCout = 1'b1;
        MARin = 1'b1;
        incPC = 1'b1;
        Zin   = 1'b1;
      end
      S_T1: begin
        ZLowOut = 1'b1;
        PCin    = 1'b1;
        read    = 1'b1;
        MDRin   = 1'b1;
      end
      // Wait cycles keep the read going without reloading the PC.
      S_T1W: begin
        read  = 1'b1;
        MDRin = 1'b1;
      end
      S_T2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      S_T3: begin
        case (cls)
          CLS_BIN: begin
            rout_en  = 1'b1;
            rout_idx = rb_q;
            Yin      = 1'b1;
          end
          CLS_MULDIV: begin
            rout_en  = 1'b1;
            rout_idx = ra_q;
            Yin      = 1'b1;
          end
          CLS_UNARY: begin
            rout_en  = 1'b1;
            rout_idx = rb_q;
            Zin      = 1'b1;
            opcode   = op_q;
          end
          default: illegal = 1'b1;
        endcase
      end
      S_T4: begin
        case (cls)
          CLS_BIN: begin
            rout_en  = 1'b1;
            rout_idx = rc_q;
            Zin      = 1'b1;
            opcode   = op_q;
          end
          CLS_MULDIV: begin
            rout_en  = 1'b1;
            rout_idx = rb_q;
            Zin      = 1'b1;
            opcode   = op_q;
          end
          CLS_UNARY: begin
            ZLowOut = 1'b1;
            rin_en  = 1'b1;
          end
          default: ;
        endcase
      end
      S_T5: begin
        case (cls)
          CLS_BIN: begin
            ZLowOut = 1'b1;
            rin_en  = 1'b1;
          end
          CLS_MULDIV: begin
            ZLowOut = 1'b1;
            LOin    = 1'b1;
          end
          default: ;
        endcase
      end
      S_T6: begin
        if (cls == CLS_MULDIV) begin
          ZHighOut = 1'b1;
          HIin     = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Destination register load enable (always Ra).
  reg_onehot_dec #(.NREG(NREG)) u_rin_dec (
    .en_i     (rin_en),
    .idx_i    (ra_q),
    .onehot_o (Rin)
  );

  // Source register bus drive enable.
  reg_onehot_dec #(.NREG(NREG)) u_rout_dec (
    .en_i     (rout_en),
    .idx_i    (rout_idx),
    .onehot_o (Rout)
  );

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a small behavioural datapath that
// moves data according to the strobes so register results can be checked.
module tb_alu_sequencer;

  localparam int NREG = 16;
  localparam int OPW  = 5;

  logic            clock = 1'b0;
  logic            clear;
  logic            run;
  logic [31:0]     ir;
  logic            mem_ready;
  logic [NREG-1:0] Rin, Rout;
  logic            PCout, incPC, MARin, PCin, read, MDRin, MDRout, IRin;
  logic            Yin, Zin, ZLowOut, ZHighOut, LOin, HIin;
  logic [OPW-1:0]  opcode;
  logic            busy, illegal;

  alu_sequencer #(.NREG(NREG), .OPW(OPW)) dut (
    .clock(clock), .clear(clear), .run(run), .ir(ir), .mem_ready(mem_ready),
    .Rin(Rin), .Rout(Rout), .PCout(PCout), .incPC(incPC), .MARin(MARin),
    .PCin(PCin), .read(read), .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin),
    .Yin(Yin), .Zin(Zin), .ZLowOut(ZLowOut), .ZHighOut(ZHighOut),
    .LOin(LOin), .HIin(HIin), .opcode(opcode), .busy(busy), .illegal(illegal)
  );

  always #5 clock = ~clock;

  localparam logic [15:0] M_PCOUT = 16'h8000, M_INCPC = 16'h4000, M_MARIN = 16'h2000;
  localparam logic [15:0] M_PCIN  = 16'h1000, M_READ  = 16'h0800, M_MDRIN = 16'h0400;
  localparam logic [15:0] M_MDROUT= 16'h0200, M_IRIN  = 16'h0100, M_YIN   = 16'h0080;
  localparam logic [15:0] M_ZIN   = 16'h0040, M_ZLO   = 16'h0020, M_ZHI   = 16'h0010;
  localparam logic [15:0] M_LOIN  = 16'h0008, M_HIIN  = 16'h0004, M_BUSY  = 16'h0002;
  localparam logic [15:0] M_ILL   = 16'h0001;

  logic [15:0] strb;
  assign strb = {PCout, incPC, MARin, PCin, read, MDRin, MDRout, IRin,
                 Yin, Zin, ZLowOut, ZHighOut, LOin, HIin, busy, illegal};

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Behavioural datapath: registers, Y, Z, PC, MDR, LO, HI.
  logic [31:0] R [NREG];
  logic [31:0] Y, PC, MDR, LO, HI;
  logic [63:0] Z;
  int          pcin_cnt;

  function automatic logic [63:0] alu(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] rr;
    case (op)
      5'b00000: alu = {32'h0, b + 32'd1};
      5'b00011: alu = {32'h0, a + b};
      5'b01000: begin
        rr  = {a, a} << b[4:0];
        alu = {32'h0, rr[63:32]};
      end
      5'b01111: alu = 64'($signed(a) * $signed(b));
      5'b10001: alu = {32'h0, -b};
      default:  alu = 64'h0;
    endcase
  endfunction

  function automatic logic [31:0] bus_val();
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < NREG; i++) if (Rout[i]) v |= R[i];
    if (ZLowOut)  v |= Z[31:0];
    if (ZHighOut) v |= Z[63:32];
    if (PCout)    v |= PC;
    if (MDRout)   v |= MDR;
    return v;
  endfunction

  task automatic dp_step();
    logic [31:0] b;
    b = bus_val();
    if (Zin)   Z = alu(opcode, Y, b);
    if (Yin)   Y = b;
    if (PCin) begin
      PC = b;
      pcin_cnt++;
    end
    if (MDRin && mem_ready) MDR = ir;
    if (LOin)  LO = b;
    if (HIin)  HI = b;
    for (int i = 0; i < NREG; i++) if (Rin[i]) R[i] = b;
  endtask

  task automatic tick();
    @(negedge clock);
    dp_step();
    #1;
  endtask

  task automatic cyc(input string tag, input logic [15:0] s, input logic [15:0] ro,
                     input logic [15:0] ri, input logic [4:0] op);
    tick();
    check_eq({tag, ".strb"}, strb, s);
    check_eq({tag, ".Rout"}, Rout, ro);
    check_eq({tag, ".Rin"},  Rin, ri);
    check_eq({tag, ".op"},   opcode, op);
  endtask

  task automatic fetch(input string tag);
    cyc({tag, ".T0"}, M_PCOUT | M_MARIN | M_INCPC | M_ZIN | M_BUSY, 16'h0, 16'h0, 5'd0);
    cyc({tag, ".T1"}, M_ZLO | M_PCIN | M_READ | M_MDRIN | M_BUSY, 16'h0, 16'h0, 5'd0);
    cyc({tag, ".T2"}, M_MDROUT | M_IRIN | M_BUSY, 16'h0, 16'h0, 5'd0);
  endtask

  task automatic wait_idle(input string tag, input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      if (!busy) break;
      tick();
    end
    check_eq({tag, ".idle"}, busy, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < NREG; i++) R[i] = '0;
    Y = '0; Z = '0; PC = '0; MDR = '0; LO = '0; HI = '0; pcin_cnt = 0;
    R[4] = 32'd10;
    R[3] = 32'd22;

    // Reset held with run high: everything quiet.
    clear     = 1'b0;
    run       = 1'b1;
    mem_ready = 1'b1;
    ir        = {5'b01000, 4'd7, 4'd4, 4'd3, 15'b0};
    cyc("rst0", 16'h0, 16'h0, 16'h0, 5'd0);
    cyc("rst1", 16'h0, 16'h0, 16'h0, 5'd0);
    clear = 1'b1;

    // rol R7 = R4 rotated left by R3 (10 rol 22).
    fetch("rol");
    run = 1'b0;
    cyc("rol.T3", M_YIN | M_BUSY, 16'h0010, 16'h0, 5'd0);
    cyc("rol.T4", M_ZIN | M_BUSY, 16'h0008, 16'h0, 5'b01000);
    cyc("rol.T5", M_ZLO | M_BUSY, 16'h0, 16'h0080, 5'd0);
    cyc("rol.idle", 16'h0, 16'h0, 16'h0, 5'd0);
    check_eq("rol.R7", R[7], 32'h0280_0000);

    // add R1 = R2 + R3 with three memory wait cycles.
    R[2] = 32'd5; R[3] = 32'd9;
    ir = {5'b00011, 4'd1, 4'd2, 4'd3, 15'b0};
    run = 1'b1;
    pcin_cnt = 0;
    cyc("ws.T0", M_PCOUT | M_MARIN | M_INCPC | M_ZIN | M_BUSY, 16'h0, 16'h0, 5'd0);
    mem_ready = 1'b0;
    cyc("ws.T1", M_ZLO | M_PCIN | M_READ | M_MDRIN | M_BUSY, 16'h0, 16'h0, 5'd0);
    cyc("ws.T1W1", M_READ | M_MDRIN | M_BUSY, 16'h0, 16'h0, 5'd0);
    cyc("ws.T1W2", M_READ | M_MDRIN | M_BUSY, 16'h0, 16'h0, 5'd0);
    cyc("ws.T1W3", M_READ | M_MDRIN | M_BUSY, 16'h0, 16'h0, 5'd0);
    mem_ready = 1'b1;
    run = 1'b0;
    cyc("ws.T2", M_MDROUT | M_IRIN | M_BUSY, 16'h0, 16'h0, 5'd0);
    check_eq("ws.pcin_once", pcin_cnt, 1);
    wait_idle("ws", 10);
    check_eq("ws.R1", R[1], 32'd14);

    // mul: LO/HI = R2 * R5, no register write.
    R[2] = 32'd6; R[5] = 32'd7;
    ir = {5'b01111, 4'd2, 4'd5, 4'd0, 15'b0};
    run = 1'b1;
    fetch("mul");
    run = 1'b0;
    cyc("mul.T3", M_YIN | M_BUSY, 16'h0004, 16'h0, 5'd0);
    cyc("mul.T4", M_ZIN | M_BUSY, 16'h0020, 16'h0, 5'b01111);
    cyc("mul.T5", M_ZLO | M_LOIN | M_BUSY, 16'h0, 16'h0, 5'd0);
    cyc("mul.T6", M_ZHI | M_HIIN | M_BUSY, 16'h0, 16'h0, 5'd0);
    cyc("mul.idle", 16'h0, 16'h0, 16'h0, 5'd0);
    check_eq("mul.LO", LO, 32'd42);
    check_eq("mul.HI", HI, 32'd0);

    // neg R8 = -R9, run kept high so the next fetch follows directly.
    R[9] = 32'd5;
    ir = {5'b10001, 4'd8, 4'd9, 4'd0, 15'b0};
    run = 1'b1;
    fetch("neg");
    cyc("neg.T3", M_ZIN | M_BUSY, 16'h0200, 16'h0, 5'b10001);
    cyc("neg.T4", M_ZLO | M_BUSY, 16'h0, 16'h0100, 5'd0);
    cyc("neg.next", M_PCOUT | M_MARIN | M_INCPC | M_ZIN | M_BUSY, 16'h0, 16'h0, 5'd0);
    check_eq("neg.R8", R[8], 32'hFFFF_FFFB);
    run = 1'b0;
    wait_idle("neg2", 10);

    // Unsupported opcode: single illegal pulse in T3, then idle.
    ir = {5'b11111, 4'd3, 4'd4, 4'd5, 15'b0};
    run = 1'b1;
    fetch("ill");
    run = 1'b0;
    cyc("ill.T3", M_ILL | M_BUSY, 16'h0, 16'h0, 5'd0);
    cyc("ill.idle", 16'h0, 16'h0, 16'h0, 5'd0);

    // clear during T4 of add: strobes drop at once, R6 untouched.
    R[6] = 32'h0000_DEAD; R[1] = 32'd3; R[2] = 32'd4;
    ir = {5'b00011, 4'd6, 4'd1, 4'd2, 15'b0};
    run = 1'b1;
    fetch("clr");
    run = 1'b0;
    cyc("clr.T3", M_YIN | M_BUSY, 16'h0002, 16'h0, 5'd0);
    cyc("clr.T4", M_ZIN | M_BUSY, 16'h0004, 16'h0, 5'b00011);
    #2;
    clear = 1'b0;
    #1;
    check_eq("clr.strb_now", strb, 16'h0);
    check_eq("clr.Rout_now", Rout, 16'h0);
    tick();
    clear = 1'b1;
    tick();
    tick();
    check_eq("clr.idle", strb, 16'h0);
    check_eq("clr.R6", R[6], 32'h0000_DEAD);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
